// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Asynchronous serial receiver. Synchronises i_rxd, finds the
//               start bit, samples every bit at mid-bit with a baud counter,
//               checks optional parity and the stop bit(s), and reports each
//               received word with a one-cycle o_valid pulse.
//               Optional build macro UART_RX_MAJORITY_EN: each bit decision is
//               the majority of three consecutive samples centred on mid-bit
//               (decision one clock later than the single-sample build).
// Ports       : i_clk        system clock
//               i_reset      synchronous reset, active high
//               i_rxd        serial line, idle high, asynchronous to i_clk
//               o_data       received word, LSB first on the line
//               o_valid      one-cycle pulse, o_data and error flags valid
//               o_parity_err parity mismatch (always 0 without parity)
//               o_frame_err  a stop bit was sampled low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter string CHECK_BIT = "None",
    parameter int    BPS       = 115200,
    parameter int    CLK       = 25_000_000,
    parameter int    DATA_BIT  = 8,
    parameter int    STOP_BIT  = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rxd,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_valid,
    output logic                o_parity_err,
    output logic                o_frame_err
);

    localparam int c_BIT_CNT = CLK / BPS - 1;
    localparam int c_HALF    = c_BIT_CNT / 2;
    localparam int c_CNT_W   = $clog2(c_BIT_CNT + 1);
    localparam int c_IDX_MAX = (DATA_BIT > STOP_BIT) ? DATA_BIT : STOP_BIT;
    localparam int c_IDX_W   = (c_IDX_MAX > 1) ? $clog2(c_IDX_MAX) : 1;
    localparam bit c_PAR_EN  = (CHECK_BIT != "None");
    localparam bit c_ODD     = (CHECK_BIT == "Odd");

`ifdef UART_RX_MAJORITY_EN
    // Decision lands on the last of the three samples, one clock past mid-bit.
    localparam int c_START_PT = c_HALF + 1;
`else
    localparam int c_START_PT = c_HALF;
`endif

    localparam logic [c_CNT_W-1:0] c_BIT_CNT_V  = c_CNT_W'(c_BIT_CNT);
    localparam logic [c_CNT_W-1:0] c_START_V    = c_CNT_W'(c_START_PT);
    localparam logic [c_IDX_W-1:0] c_DATA_LAST  = c_IDX_W'(DATA_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST  = c_IDX_W'(STOP_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [c_CNT_W-1:0]    r_cnt_q,   w_cnt_d;
    logic [c_IDX_W-1:0]    r_idx_q,   w_idx_d;
    logic [DATA_BIT-1:0]   r_shift_q, w_shift_d;
    logic                  r_perr_q,  w_perr_d;
    logic                  r_ferr_q,  w_ferr_d;
    logic [DATA_BIT-1:0]   r_data_q,  w_data_d;
    logic                  r_valid_q, w_valid_d;
    logic                  r_operr_q, w_operr_d;
    logic                  r_oferr_q, w_oferr_d;

    logic                  r_rxd_meta_q;
    logic                  r_rxd_s_q;
    logic                  r_rxd_prev_q;
    logic                  w_bit;
    logic                  w_tick;
    logic                  w_par_exp;

    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxd_meta_q <= 1'b1;
            r_rxd_s_q    <= 1'b1;
            r_rxd_prev_q <= 1'b1;
        end else begin
            r_rxd_meta_q <= i_rxd;
            r_rxd_s_q    <= r_rxd_meta_q;
            r_rxd_prev_q <= r_rxd_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hist_q <= 2'b11;
        end else begin
            r_hist_q <= {r_hist_q[0], r_rxd_s_q};
        end
    end

    assign w_bit = (r_hist_q[1] & r_hist_q[0]) |
                   (r_hist_q[1] & r_rxd_s_q)   |
                   (r_hist_q[0] & r_rxd_s_q);
`else
    assign w_bit = r_rxd_s_q;
`endif

    assign w_tick    = (r_cnt_q == c_BIT_CNT_V);
    assign w_par_exp = c_ODD ? ~(^r_shift_q) : (^r_shift_q);

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_idx_d   = r_idx_q;
        w_shift_d = r_shift_q;
        w_perr_d  = r_perr_q;
        w_ferr_d  = r_ferr_q;
        w_data_d  = r_data_q;
        w_valid_d = 1'b0;
        w_operr_d = r_operr_q;
        w_oferr_d = r_oferr_q;

        case (r_state_q)
            S_IDLE: begin
                w_cnt_d = '0;
                if (r_rxd_prev_q && !r_rxd_s_q) begin
                    w_state_d = S_START;
                end
            end
            S_START: begin
                if (r_cnt_q == c_START_V) begin
                    w_cnt_d = '0;
                    if (w_bit) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        w_state_d = S_IDLE;
                    end else begin
                        w_state_d = S_DATA;
                        w_idx_d   = '0;
                        w_perr_d  = 1'b0;
                        w_ferr_d  = 1'b0;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_bit, r_shift_q[DATA_BIT-1:1]};
                    if (r_idx_q == c_DATA_LAST) begin
                        w_idx_d   = '0;
                        w_state_d = c_PAR_EN ? S_CHECK : S_STOP;
                    end else begin
                        w_idx_d = r_idx_q + 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (w_tick) begin
                    w_cnt_d   = '0;
                    w_perr_d  = (w_bit != w_par_exp);
                    w_state_d = S_STOP;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_cnt_d  = '0;
                    w_ferr_d = r_ferr_q | ~w_bit;
                    if (r_idx_q == c_STOP_LAST) begin
                        w_idx_d   = '0;
                        w_valid_d = 1'b1;
                        w_data_d  = r_shift_q;
                        w_operr_d = r_perr_q;
                        w_oferr_d = r_ferr_q | ~w_bit;
                        // A low stop bit may be a break: wait for the line to
                        // return high so the held-low level is not a new start.
                        w_state_d = (r_ferr_q | ~w_bit) ? S_BREAK : S_IDLE;
                    end else begin
                        w_idx_d = r_idx_q + 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                w_cnt_d = '0;
                if (r_rxd_s_q) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_shift_q <= '0;
            r_perr_q  <= 1'b0;
            r_ferr_q  <= 1'b0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_operr_q <= 1'b0;
            r_oferr_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_shift_q <= w_shift_d;
            r_perr_q  <= w_perr_d;
            r_ferr_q  <= w_ferr_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_operr_q <= w_operr_d;
            r_oferr_q <= w_oferr_d;
        end
    end

    assign o_data       = r_data_q;
    assign o_valid      = r_valid_q;
    assign o_parity_err = r_operr_q;
    assign o_frame_err  = r_oferr_q;

endmodule
`default_nettype wire
